// File: rtl/cov_toggle_collector_if.sv
// Counter-dump stream between the toggle collector (master) and its reader (slave).
interface cov_toggle_collector_if #(
  parameter int CH_W  = 3,
  parameter int CNT_W = 16
);
  logic             rd_req;
  logic             rd_valid;
  logic             rd_ready;
  logic [CH_W-1:0]  rd_ch;
  logic [CNT_W-1:0] rd_cnt;
  logic             rd_last;

  modport master (
    input  rd_req, rd_ready,
    output rd_valid, rd_ch, rd_cnt, rd_last
  );

  modport slave (
    output rd_req, rd_ready,
    input  rd_valid, rd_ch, rd_cnt, rd_last
  );
endinterface

// File: rtl/cov_toggle_collector.sv
// Toggle-coverage collector: counts per-channel value changes and dumps the
// counters one channel per beat over a valid/ready stream.
module cov_toggle_collector #(
  parameter int NUM_CH     = 8,
  parameter int SIG_W      = 8,
  parameter int CNT_W      = 16,
  parameter int HIT_THRESH = 1,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int COV_W     = $clog2(NUM_CH + 1)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_CH*SIG_W-1:0] sig_in,
  input  logic                    cov_en,
  input  logic                    cov_clear,
  cov_toggle_collector_if.master  rd,
  output logic [COV_W-1:0]        covered_cnt,
  output logic                    busy
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] THRESH  = CNT_W'(HIT_THRESH);
  localparam logic [CH_W-1:0]  LAST_CH = CH_W'(NUM_CH - 1);

  typedef enum logic {IDLE, DUMP} state_t;

  logic [SIG_W-1:0]  last_q [NUM_CH];
  logic [SIG_W-1:0]  last_d [NUM_CH];
  logic [CNT_W-1:0]  cnt_q  [NUM_CH];
  logic [CNT_W-1:0]  cnt_d  [NUM_CH];
  logic [NUM_CH-1:0] primed_q, primed_d;
  logic [NUM_CH-1:0] covered_q, covered_d;
  logic [COV_W-1:0]  covered_cnt_q, covered_cnt_d;
  state_t            state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;

  // The first enabled sample after reset/clear only primes last-value.
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      last_d[k]    = last_q[k];
      cnt_d[k]     = cnt_q[k];
      primed_d[k]  = primed_q[k];
      covered_d[k] = covered_q[k] | (cnt_q[k] >= THRESH);
      if (cov_clear) begin
        cnt_d[k]     = '0;
        primed_d[k]  = 1'b0;
        covered_d[k] = 1'b0;
      end else if (cov_en) begin
        last_d[k]   = sig_in[k*SIG_W +: SIG_W];
        primed_d[k] = 1'b1;
        if (primed_q[k] && (sig_in[k*SIG_W +: SIG_W] != last_q[k]) && (cnt_q[k] != CNT_MAX)) begin
          cnt_d[k] = cnt_q[k] + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    covered_cnt_d = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      covered_cnt_d = covered_cnt_d + COV_W'(covered_q[k]);
    end
  end

  // Each beat's count is sampled on the edge that presents it.
  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    rd_cnt_d = rd_cnt_q;
    case (state_q)
      IDLE: begin
        if (rd.rd_req) begin
          state_d  = DUMP;
          ch_d     = '0;
          rd_cnt_d = cnt_q[0];
        end
      end
      DUMP: begin
        if (rd.rd_ready) begin
          if (ch_q == LAST_CH) begin
            state_d  = IDLE;
            ch_d     = '0;
            rd_cnt_d = '0;
          end else begin
            ch_d     = ch_q + CH_W'(1);
            rd_cnt_d = cnt_q[ch_d];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < NUM_CH; k++) begin
        last_q[k] <= '0;
        cnt_q[k]  <= '0;
      end
      primed_q      <= '0;
      covered_q     <= '0;
      covered_cnt_q <= '0;
      state_q       <= IDLE;
      ch_q          <= '0;
      rd_cnt_q      <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        last_q[k] <= last_d[k];
        cnt_q[k]  <= cnt_d[k];
      end
      primed_q      <= primed_d;
      covered_q     <= covered_d;
      covered_cnt_q <= covered_cnt_d;
      state_q       <= state_d;
      ch_q          <= ch_d;
      rd_cnt_q      <= rd_cnt_d;
    end
  end

  assign rd.rd_valid = (state_q == DUMP);
  assign rd.rd_ch    = ch_q;
  assign rd.rd_cnt   = rd_cnt_q;
  assign rd.rd_last  = (state_q == DUMP) && (ch_q == LAST_CH);
  assign busy        = (state_q == DUMP);
  assign covered_cnt = covered_cnt_q;

endmodule

// File: tb/tb_cov_toggle_collector.sv
// Bench for cov_toggle_collector: vector table, hand-written dump/reset
// sequences, a saturating 2-bit instance and a randomized model comparison.
module tb_cov_toggle_collector;
  localparam int NUM_CH = 8;
  localparam int SIG_W  = 8;
  localparam int CNT_W  = 16;
  localparam int CH_W   = 3;
  localparam int COV_W  = 4;
  localparam int MAXC   = 65535;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [NUM_CH*SIG_W-1:0] sig_in = '0;
  logic                    cov_en = 1'b0;
  logic                    cov_clear = 1'b0;
  logic [COV_W-1:0]        covered_cnt;
  logic                    busy;

  cov_toggle_collector_if #(.CH_W(CH_W), .CNT_W(CNT_W)) rd ();

  cov_toggle_collector #(.NUM_CH(NUM_CH), .SIG_W(SIG_W), .CNT_W(CNT_W), .HIT_THRESH(1)) dut (
    .clock(clock), .reset(reset), .sig_in(sig_in), .cov_en(cov_en), .cov_clear(cov_clear),
    .rd(rd), .covered_cnt(covered_cnt), .busy(busy)
  );

  // Small instance with 2-bit counters for saturation.
  logic [31:0] s_sig = '0;
  logic        s_en = 1'b0;
  logic        s_clr = 1'b0;
  logic [2:0]  s_cov;
  logic        s_busy;

  cov_toggle_collector_if #(.CH_W(2), .CNT_W(2)) rd2 ();

  cov_toggle_collector #(.NUM_CH(4), .SIG_W(8), .CNT_W(2), .HIT_THRESH(1)) dut2 (
    .clock(clock), .reset(reset), .sig_in(s_sig), .cov_en(s_en), .cov_clear(s_clr),
    .rd(rd2), .covered_cnt(s_cov), .busy(s_busy)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: toggle counts per channel derived from the sampling rules.
  int               mcnt   [NUM_CH];
  bit               mprimed[NUM_CH];
  logic [SIG_W-1:0] mlast  [NUM_CH];

  function automatic void model_edge();
    logic [SIG_W-1:0] v;
    for (int k = 0; k < NUM_CH; k++) begin
      v = sig_in[k*SIG_W +: SIG_W];
      if (reset) begin
        mcnt[k] = 0; mprimed[k] = 0; mlast[k] = '0;
      end else if (cov_clear) begin
        mcnt[k] = 0; mprimed[k] = 0;
      end else if (cov_en) begin
        if (mprimed[k] && v != mlast[k]) mcnt[k] = (mcnt[k] + 1 > MAXC) ? MAXC : mcnt[k] + 1;
        mlast[k]   = v;
        mprimed[k] = 1;
      end
    end
  endfunction

  function automatic int model_covered();
    int n = 0;
    for (int k = 0; k < NUM_CH; k++) if (mcnt[k] >= 1) n++;
    return n;
  endfunction

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Dump: stall the first beat, then accept `upto` beats back to back.
  task automatic dump(input int stall, input int upto, input int expc[NUM_CH], input string tag);
    rd.rd_req = 1'b1;
    step();
    rd.rd_req = 1'b0;
    for (int s = 0; s < stall; s++) begin
      chk({tag, "_stall_vld"}, rd.rd_valid, 1);
      chk({tag, "_stall_ch"}, rd.rd_ch, 0);
      chk({tag, "_stall_cnt"}, rd.rd_cnt, expc[0]);
      rd.rd_req = 1'b1;
      step();
      rd.rd_req = 1'b0;
    end
    for (int b = 0; b < upto; b++) begin
      chk($sformatf("%s_b%0d_vld", tag, b), rd.rd_valid, 1);
      chk($sformatf("%s_b%0d_ch", tag, b), rd.rd_ch, b);
      chk($sformatf("%s_b%0d_cnt", tag, b), rd.rd_cnt, expc[b]);
      chk($sformatf("%s_b%0d_last", tag, b), rd.rd_last, (b == NUM_CH - 1));
      chk($sformatf("%s_b%0d_busy", tag, b), busy, 1);
      rd.rd_ready = 1'b1;
      step();
      rd.rd_ready = 1'b0;
    end
    if (upto == NUM_CH) begin
      chk({tag, "_end_vld"}, rd.rd_valid, 0);
      chk({tag, "_end_busy"}, busy, 0);
    end
  endtask

  task automatic dump_small(input string tag);
    rd2.rd_req = 1'b1;
    step();
    rd2.rd_req = 1'b0;
    rd2.rd_ready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      chk($sformatf("%s_b%0d_ch", tag, b), rd2.rd_ch, b);
      chk($sformatf("%s_b%0d_cnt", tag, b), rd2.rd_cnt, (b == 3) ? 3 : 0);
      chk($sformatf("%s_b%0d_last", tag, b), rd2.rd_last, (b == 3));
      step();
    end
    rd2.rd_ready = 1'b0;
    chk({tag, "_end_vld"}, rd2.rd_valid, 0);
  endtask

  typedef struct {
    logic       en;
    logic       clr;
    logic [7:0] c0, c1, c2;
    int         exp_cov;
    logic       dmp;
    int         e0, e1, e2;
  } vec_t;

  vec_t tbl[17];

  initial begin
    int e[NUM_CH];
    int zero[NUM_CH];
    logic [NUM_CH-1:0] act_mask;

    rd.rd_req = 1'b0; rd.rd_ready = 1'b0;
    rd2.rd_req = 1'b0; rd2.rd_ready = 1'b0;
    zero = '{default: 0};

    tbl[0]  = '{1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 0, 1'b0, 0, 0, 0};
    tbl[1]  = '{1'b1, 1'b0, 8'h01, 8'h00, 8'h00, 0, 1'b0, 0, 0, 0};
    tbl[2]  = '{1'b1, 1'b0, 8'h01, 8'h00, 8'h00, 0, 1'b0, 0, 0, 0};
    tbl[3]  = '{1'b1, 1'b0, 8'hFF, 8'h00, 8'h00, 1, 1'b0, 0, 0, 0};
    tbl[4]  = '{1'b0, 1'b0, 8'hFF, 8'h00, 8'h00, 1, 1'b1, 2, 0, 0};
    tbl[5]  = '{1'b1, 1'b0, 8'hFF, 8'h00, 8'h00, 1, 1'b0, 0, 0, 0};
    tbl[6]  = '{1'b1, 1'b1, 8'hFF, 8'h00, 8'h5A, 1, 1'b0, 0, 0, 0};
    tbl[7]  = '{1'b0, 1'b0, 8'hFF, 8'h00, 8'h5A, 0, 1'b0, 0, 0, 0};
    tbl[8]  = '{1'b0, 1'b0, 8'hFF, 8'h00, 8'h5A, 0, 1'b1, 0, 0, 0};
    tbl[9]  = '{1'b0, 1'b0, 8'hFF, 8'h01, 8'h5A, 0, 1'b0, 0, 0, 0};
    tbl[10] = '{1'b0, 1'b0, 8'hFF, 8'h00, 8'h5A, 0, 1'b0, 0, 0, 0};
    tbl[11] = '{1'b0, 1'b0, 8'hFF, 8'h01, 8'h5A, 0, 1'b0, 0, 0, 0};
    tbl[12] = '{1'b0, 1'b0, 8'hFF, 8'h00, 8'h5A, 0, 1'b0, 0, 0, 0};
    tbl[13] = '{1'b0, 1'b0, 8'hFF, 8'h01, 8'h5A, 0, 1'b0, 0, 0, 0};
    tbl[14] = '{1'b1, 1'b0, 8'hFF, 8'h01, 8'h5A, 0, 1'b0, 0, 0, 0};
    tbl[15] = '{1'b1, 1'b0, 8'hFF, 8'h01, 8'h5A, 0, 1'b0, 0, 0, 0};
    tbl[16] = '{1'b0, 1'b0, 8'hFF, 8'h01, 8'h5A, 0, 1'b1, 0, 0, 0};

    // Reset values
    reset = 1'b1;
    step(); step();
    chk("rst_vld", rd.rd_valid, 0);
    chk("rst_ch", rd.rd_ch, 0);
    chk("rst_cnt", rd.rd_cnt, 0);
    chk("rst_last", rd.rd_last, 0);
    chk("rst_cov", covered_cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst2_vld", rd2.rd_valid, 0);
    reset = 1'b0;

    // Vector table: priming, counting, clear-vs-toggle, disabled toggles
    for (int i = 0; i < 17; i++) begin
      cov_en    = tbl[i].en;
      cov_clear = tbl[i].clr;
      sig_in[7:0]   = tbl[i].c0;
      sig_in[15:8]  = tbl[i].c1;
      sig_in[23:16] = tbl[i].c2;
      step();
      cov_clear = 1'b0;
      chk($sformatf("vec%0d_cov", i), covered_cnt, tbl[i].exp_cov);
      if (tbl[i].dmp) begin
        e = zero;
        e[0] = tbl[i].e0; e[1] = tbl[i].e1; e[2] = tbl[i].e2;
        dump(1, NUM_CH, e, $sformatf("vec%0d", i));
      end
    end

    // Counts {5,0,1,0,0,0,0,2}, dump with a 3-cycle initial stall
    reset = 1'b1; step(); reset = 1'b0;
    sig_in = '0; cov_en = 1'b1;
    step();
    for (int i = 1; i <= 5; i++) begin
      sig_in[7:0]   = (i % 2 == 1) ? 8'h01 : 8'h00;
      sig_in[23:16] = 8'h01;
      sig_in[63:56] = (i == 1) ? 8'h01 : 8'h00;
      step();
    end
    cov_en = 1'b0;
    step(); step();
    chk("seq_cov", covered_cnt, 3);
    e = '{5, 0, 1, 0, 0, 0, 0, 2};
    dump(3, NUM_CH, e, "stall");

    // Reset after the third accepted beat aborts the dump
    dump(0, 3, e, "abort");
    chk("abort_pre_ch", rd.rd_ch, 3);
    reset = 1'b1; step(); reset = 1'b0;
    chk("abort_vld", rd.rd_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_cov", covered_cnt, 0);
    chk("abort_ch", rd.rd_ch, 0);
    step();
    chk("abort_idle_vld", rd.rd_valid, 0);
    dump(0, NUM_CH, zero, "restart");

    // 2-bit counters saturate at 3 and never wrap
    s_en = 1'b1; s_sig = '0;
    step();
    for (int i = 0; i < 9; i++) begin s_sig[31:24] = ~s_sig[31:24]; step(); end
    s_en = 1'b0;
    dump_small("sat1");
    s_en = 1'b1;
    for (int i = 0; i < 10; i++) begin s_sig[31:24] = ~s_sig[31:24]; step(); end
    s_en = 1'b0;
    dump_small("sat2");

    // Randomized traffic against the reference model
    for (int r = 0; r < 8; r++) begin
      act_mask = NUM_CH'($urandom);
      for (int c = 0; c < 40; c++) begin
        cov_en    = ($urandom_range(0, 3) != 0);
        cov_clear = ($urandom_range(0, 59) == 0);
        for (int k = 0; k < NUM_CH; k++)
          if (act_mask[k] && $urandom_range(0, 2) == 0) sig_in[k*SIG_W +: SIG_W] = 8'($urandom);
        step();
      end
      cov_en = 1'b0; cov_clear = 1'b0;
      step(); step();
      chk($sformatf("rnd%0d_cov", r), covered_cnt, model_covered());
      dump($urandom_range(0, 3), NUM_CH, mcnt, $sformatf("rnd%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/cov_toggle_collector.md
COV_TOGGLE_COLLECTOR -- requirements
Module: cov_toggle_collector

Interface
REQ-001 SHALL have parameter NUM_CH, default 8: number of monitored channels (1..64).
REQ-002 SHALL have parameter SIG_W, default 8: width of each monitored signal (1..64).
REQ-003 SHALL have parameter CNT_W, default 16: width of each toggle counter (2..32).
REQ-004 SHALL have parameter HIT_THRESH, default 1: toggle count at which a channel is covered (1..2^CNT_W-1).
REQ-005 SHALL define CH_W = max(1, clog2(NUM_CH)) and COV_W = clog2(NUM_CH+1).
REQ-006 clock  input  1  rising-edge clock for all state.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 sig_in  input  NUM_CH*SIG_W  monitored signals; channel k occupies bits [k*SIG_W +: SIG_W].
REQ-009 cov_en  input  1  sampling enable; no priming, counting or last-value update while low.
REQ-010 cov_clear  input  1  single-cycle pulse; clears all coverage state.
REQ-011 rd_req  input  1  pulse; starts a dump of all channel counters.
REQ-012 rd_valid  output  1  dump beat valid.
REQ-013 rd_ready  input  1  consumer accepts the beat.
REQ-014 rd_ch  output  CH_W  channel index of the current beat.
REQ-015 rd_cnt  output  CNT_W  toggle count of the current beat.
REQ-016 rd_last  output  1  current beat is channel NUM_CH-1.
REQ-017 covered_cnt  output  COV_W  number of channels whose count >= HIT_THRESH.
REQ-018 busy  output  1  high while the dump FSM is in DUMP.

Function
REQ-019 Per channel: SIG_W last-value register, primed flag, CNT_W counter, covered flag.
REQ-020 When cov_en=1 and the primed flag is 0, the block SHALL capture sig_in into last-value and set primed, without counting.
REQ-021 When cov_en=1 and primed=1, the block SHALL increment the counter by 1 if sig_in differs from last-value in any bit, and SHALL update last-value every enabled cycle.
REQ-022 Counters SHALL saturate at 2^CNT_W-1 without wrapping.
REQ-023 The covered flag SHALL be set in the cycle after the counter reaches HIT_THRESH, and SHALL remain set until clear or reset.
REQ-024 covered_cnt SHALL be the registered popcount of the covered flags, one cycle after the flags change.
REQ-025 cov_clear SHALL zero counters, primed and covered flags on the next edge; clear SHALL override a same-cycle toggle increment.
REQ-026 The dump FSM SHALL have states IDLE and DUMP.
REQ-027 IDLE: rd_req=1 -> DUMP; on the next cycle rd_valid=1, rd_ch=0, and rd_cnt = channel 0 counter sampled at that edge.
REQ-028 DUMP: on rd_valid&rd_ready with rd_last=0, the block SHALL present the next channel in the following cycle with a freshly sampled count (no bubble).
REQ-029 DUMP: on rd_valid&rd_ready with rd_last=1 -> IDLE, with rd_valid=0 in the next cycle.
REQ-030 While rd_valid=1 and rd_ready=0, rd_ch, rd_cnt and rd_last SHALL hold stable.
REQ-031 rd_req during DUMP SHALL be ignored.
REQ-032 Counting SHALL continue during a dump; cov_clear during a dump SHALL NOT abort it, and later-sampled beats SHALL reflect the cleared values.
REQ-033 NUM_CH=1 SHALL yield single-beat dumps with rd_last=1.

Reset
REQ-034 On reset, all counters, primed flags, covered flags and last-value registers SHALL be 0, and the FSM SHALL be in IDLE.
REQ-035 On reset, the outputs SHALL be rd_valid=0, rd_ch=0, rd_cnt=0, rd_last=0, covered_cnt=0 and busy=0.
REQ-036 Reset asserted during DUMP SHALL abort the dump at the next edge, with no further beats.

Verification
REQ-037 Defaults; cov_en=1; ch0 driven 0x00,0x01,0x01,0xFF over 4 cycles -> ch0 count=2, covered_cnt=1, other channels 0.
REQ-038 CNT_W=2; ch3 toggles every cycle for 10 cycles -> count holds 3 (saturated), never 0.
REQ-039 cov_en=0 while ch1 toggles 5 times, then cov_en=1 with a steady value -> ch1 count=0 (first enabled sample only primes).
REQ-040 Counts {5,0,1,0,0,0,0,2}; rd_req with rd_ready low for 3 cycles then high -> 8 beats in order ch0..7, values match, rd_cnt stable while stalled, rd_last only on ch7, busy drops after the last beat.
REQ-041 Same cycle: cov_clear=1 and a ch2 toggle -> ch2 count=0, covered_cnt=0 two cycles later.
REQ-042 Reset asserted after the 3rd beat of a dump -> rd_valid=0 next cycle, all counts 0, a subsequent rd_req restarts from ch0.
